irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Per-tile interrupt controller directly downstream of the tile SFR block.
- Latches the SFR's single-cycle timer and software-generated-interrupt (SGI) pulses, plus external lines, into a pending register, and masks them.
- Arbitrates by fixed priority and presents one interrupt at a time to the CPU core over a req/ack handshake.
- Memory-mapped on a MemSplit32 slave port for mask/pending control.

Parameters:
- IRQ_NUM_POW, 4: log2 of the line count; IRQ_NUM = 2**IRQ_NUM_POW.
- TIMER_IRQ_LINE, 1: pending bit index set by irq_timer_i.
- MASK_DEFAULT, 0: reset value of the MASK register (IRQ_NUM bits).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- host  MemSplit32.Slave  -  register access (req, ack, we, addr, wdata, resp, rdata).
- irq_timer_i  in  1  timer pulse from SFR.
- sgi_req_i  in  1  SGI pulse from SFR.
- sgi_code_bi  in  IRQ_NUM_POW  SGI line index, valid with sgi_req_i.
- ext_irq_bi  in  IRQ_NUM  external sources; set-only, sampled each cycle.
- irq_req_o  out  1  interrupt request to CPU.
- irq_code_bo  out  IRQ_NUM_POW  index of the requested line.
- irq_ack_i  in  1  CPU accepts the current request.

Behaviour:
- Reset (rst_ni=0 at posedge) clears the following: pending=0, mask=MASK_DEFAULT, irq_req_o=0, irq_code_bo=0, host.resp=0, host.rdata=0, FSM=IDLE.
- Set vector each cycle: ext_irq_bi | (irq_timer_i << TIMER_IRQ_LINE) | (sgi_req_i ? 1<<sgi_code_bi : 0) | SWSET write data.
- Pending update: pending <= (pending & ~clr) | set.
  - clr = W1C write data | onehot(irq_code_bo) on ack.
  - Set wins over clear on the same bit in the same cycle.
- Register map, decoded on host.addr[7:0]:
  - 0x00 MASK: RW; bit=1 enables the line.
  - 0x04 PENDING: R; write-1-to-clear.
  - 0x08 SWSET: W; ORs wdata into pending. Reads 0.
  - 0x0C STATUS: R; {irq_req_o at bit 31, irq_code_bo at bits IRQ_NUM_POW-1:0}.
  - Writes to unmapped addresses are ignored.
  - Reads of unmapped addresses return 0.
- Host handshake:
  - host.ack = host.req, combinational.
  - Writes take effect at the req edge; no resp is generated for writes.
  - Reads: host.resp=1 exactly one cycle after the req cycle, with rdata valid that cycle. rdata holds its value otherwise.
  - A read of PENDING returns the pre-update value of the req cycle.
- FSM:
  - IDLE: if |(pending & mask), load irq_code_bo with the lowest set index of (pending & mask), set irq_req_o=1, go REQ. Latency: a pulse in cycle N is pending at N+1 and irq_req_o=1 at N+2.
  - REQ: irq_req_o and irq_code_bo are held stable. Later higher-priority arrivals do not preempt. A MASK write does not withdraw the request.
  - On irq_ack_i in REQ: clear pending[irq_code_bo], set irq_req_o=0 next cycle, go IDLE. The minimum gap between two requests is one cycle with irq_req_o=0.
  - If a W1C clears the in-flight bit, the request stays up until ack. The ack-side clear is then a no-op.
  - irq_ack_i while in IDLE is ignored.
- Re-arrival of the in-flight line in the ack cycle leaves it pending; it is re-requested after the gap.
- Reset mid-REQ drops irq_req_o the next cycle; all pending state is lost.
- sgi_code_bi is only used when sgi_req_i=1.

Optional Feature:
- IRQ_CTRL_STATS_EN defined:
  - Adds a 32-bit accepted-interrupt counter, incremented on each ack in REQ and wrapping 0xFFFFFFFF->0.
  - Readable at 0x10; any write to 0x10 clears it (write beats increment).
  - Reset value 0.
- Undefined: no counter logic; 0x10 behaves as unmapped (reads 0).

Test Plan:
- Reset: after reset, read MASK -> MASK_DEFAULT, PENDING -> 0, irq_req_o=0.
- Timer path: MASK=0x0002; 1-cycle irq_timer_i pulse at cycle N -> irq_req_o=1 and irq_code_bo=1 at N+2; ack -> PENDING reads 0 and irq_req_o=0.
- Priority: MASK=0xFFFF; SWSET 0x0030 -> code 4 requested; ack -> one cycle of irq_req_o=0, then code 5; SGI code 2 arriving while code 5 is pending does not preempt.
- Masking: MASK=0; ext_irq_bi=0x0100 pulse -> PENDING=0x0100 and no req; then MASK=0x0100 -> req with code 8.
- Collisions:
  - W1C 0x0008 while ext_irq_bi[3] is pulsing -> bit 3 stays set.
  - Ack coincident with re-arrival of the in-flight line -> line is re-requested after the gap.
- Stats (IRQ_CTRL_STATS_EN): 3 acks -> read 0x10 returns 3; write 0x10 -> reads 0. Without the macro, 0x10 reads 0.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// MemSplit32 register-access bus: single-cycle request with a combinational
// ack, and a one-cycle-later read response carrying rdata.
interface MemSplit32;
  logic        req;
  logic        ack;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp;
  logic [31:0] rdata;

  modport Master (output req, we, addr, wdata, input  ack, resp, rdata);
  modport Slave  (input  req, we, addr, wdata, output ack, resp, rdata);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: per-tile interrupt controller.
// Latches timer/SGI pulses and external lines into a pending register, masks
// them, and presents the lowest-index enabled line to the CPU over req/ack.
// Optional feature macro: IRQ_CTRL_STATS_EN adds an accepted-interrupt
// counter at 0x10 (any write clears it).
module irq_ctrl #(
  parameter int                           IRQ_NUM_POW    = 4,
  parameter int                           TIMER_IRQ_LINE = 1,
  parameter logic [(2**IRQ_NUM_POW)-1:0]  MASK_DEFAULT   = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  MemSplit32.Slave               host,
  input  logic                   irq_timer_i,
  input  logic                   sgi_req_i,
  input  logic [IRQ_NUM_POW-1:0] sgi_code_bi,
  input  logic [(2**IRQ_NUM_POW)-1:0] ext_irq_bi,
  output logic                   irq_req_o,
  output logic [IRQ_NUM_POW-1:0] irq_code_bo,
  input  logic                   irq_ack_i
);

  localparam int IRQ_NUM = 2**IRQ_NUM_POW;

  localparam logic [7:0] ADDR_MASK    = 8'h00;
  localparam logic [7:0] ADDR_PENDING = 8'h04;
  localparam logic [7:0] ADDR_SWSET   = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;
`ifdef IRQ_CTRL_STATS_EN
  localparam logic [7:0] ADDR_STATS   = 8'h10;
`endif

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                 r_state;
  logic [IRQ_NUM-1:0]     r_pending;
  logic [IRQ_NUM-1:0]     r_mask;
  logic                   r_irq_req;
  logic [IRQ_NUM_POW-1:0] r_irq_code;
  logic                   r_resp;
  logic [31:0]            r_rdata;
`ifdef IRQ_CTRL_STATS_EN
  logic [31:0]            r_stats;
`endif

  logic [7:0]             w_addr;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_ack_hit;
  logic [IRQ_NUM-1:0]     w_set;
  logic [IRQ_NUM-1:0]     w_clr;
  logic [IRQ_NUM-1:0]     w_masked;
  logic [IRQ_NUM_POW-1:0] w_lowest;
  logic [31:0]            w_rd_mux;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  function automatic logic [IRQ_NUM_POW-1:0] lowest_index(input logic [IRQ_NUM-1:0] v);
    lowest_index = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = i[IRQ_NUM_POW-1:0];
    end
  endfunction

  assign w_addr    = host.addr[7:0];
  assign w_wr      = host.req & host.we;
  assign w_rd      = host.req & ~host.we;
  assign w_ack_hit = (r_state == S_REQ) & irq_ack_i;
  assign w_masked  = r_pending & r_mask;
  assign w_lowest  = lowest_index(w_masked);

  assign host.ack    = host.req;
  assign host.resp   = r_resp;
  assign host.rdata  = r_rdata;
  assign irq_req_o   = r_irq_req;
  assign irq_code_bo = r_irq_code;

  // Build the per-cycle set/clear vectors for the pending register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_set = ext_irq_bi;
    w_set[TIMER_IRQ_LINE] = ext_irq_bi[TIMER_IRQ_LINE] | irq_timer_i;
    if (sgi_req_i) w_set[sgi_code_bi] = 1'b1;
    if (w_wr && w_addr == ADDR_SWSET) w_set = w_set | host.wdata[IRQ_NUM-1:0];

    w_clr = '0;
    if (w_wr && w_addr == ADDR_PENDING) w_clr = host.wdata[IRQ_NUM-1:0];
    if (w_ack_hit) w_clr[r_irq_code] = 1'b1;
  end

  // Read data mux; values are those before this cycle's update.
  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      ADDR_MASK:    w_rd_mux = 32'(r_mask);
      ADDR_PENDING: w_rd_mux = 32'(r_pending);
      ADDR_STATUS: begin
        w_rd_mux[31]              = r_irq_req;
        w_rd_mux[IRQ_NUM_POW-1:0] = r_irq_code;
      end
`ifdef IRQ_CTRL_STATS_EN
      ADDR_STATS:   w_rd_mux = r_stats;
`endif
      default:      w_rd_mux = '0;
    endcase
  end

  // Pending/mask registers and the host read response.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_ni) begin
      r_pending <= '0;
      r_mask    <= MASK_DEFAULT;
      r_resp    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      // Set is ORed in after the clear, so set wins on a collision.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr && w_addr == ADDR_MASK) r_mask <= host.wdata[IRQ_NUM-1:0];
      r_resp <= w_rd;
      if (w_rd) r_rdata <= w_rd_mux;
    end
  end

  // Request FSM: pick the lowest enabled pending line and hold it until ack.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_irq_req  <= 1'b0;
      r_irq_code <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_masked) begin
            r_irq_code <= w_lowest;
            r_irq_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // No preemption and no withdrawal: only ack ends the request.
          if (irq_ack_i) begin
            r_irq_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_irq_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IRQ_CTRL_STATS_EN
  // Accepted-interrupt counter; a host write to it takes priority over an ack.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stats <= '0;
    end else if (w_wr && w_addr == ADDR_STATS) begin
      r_stats <= '0;
    end else if (w_ack_hit) begin
      r_stats <= r_stats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus a randomized run, all
// checked against a cycle-level reference model of the controller's rules.
module tb_irq_ctrl;

  localparam int          IRQ_NUM_POW    = 4;
  localparam int          IRQ_NUM        = 16;
  localparam int          TIMER_IRQ_LINE = 1;
  localparam logic [15:0] MASK_DEFAULT   = 16'h0000;
`ifdef IRQ_CTRL_STATS_EN
  localparam bit          STATS_ON       = 1'b1;
`else
  localparam bit          STATS_ON       = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_timer;
  logic        sgi_req;
  logic [3:0]  sgi_code;
  logic [15:0] ext_irq;
  logic        irq_ack;
  logic        irq_req;
  logic [3:0]  irq_code;

  int errors = 0;
  int checks = 0;

  MemSplit32 host_bus ();

  irq_ctrl #(
    .IRQ_NUM_POW    (IRQ_NUM_POW),
    .TIMER_IRQ_LINE (TIMER_IRQ_LINE),
    .MASK_DEFAULT   (MASK_DEFAULT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .host        (host_bus),
    .irq_timer_i (irq_timer),
    .sgi_req_i   (sgi_req),
    .sgi_code_bi (sgi_code),
    .ext_irq_bi  (ext_irq),
    .irq_req_o   (irq_req),
    .irq_code_bo (irq_code),
    .irq_ack_i   (irq_ack)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_pend;
  logic [15:0] m_mask;
  bit          m_req;
  logic [3:0]  m_code;
  bit          m_resp;
  logic [31:0] m_rdata;
  logic [31:0] m_stats;

  function automatic int first_one(input logic [15:0] v);
    for (int i = 0; i < IRQ_NUM; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return {16'h0, m_mask};
      8'h04:   return {16'h0, m_pend};
      8'h0C:   return {m_req, 27'h0, m_code};
      8'h10:   return STATS_ON ? m_stats : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Advance model and DUT by one clock, using inputs as they stand before the edge.
  task automatic step();
    logic [15:0] set_v, clr_v, n_pend, n_mask;
    logic [31:0] n_stats, n_rdata;
    logic [3:0]  n_code;
    bit          n_req, n_resp, wr, rd, acked;
    logic [7:0]  a;
    int          first;
    a     = host_bus.addr[7:0];
    wr    = host_bus.req && host_bus.we;
    rd    = host_bus.req && !host_bus.we;
    acked = m_req && irq_ack;
    set_v = ext_irq | (16'(irq_timer) << TIMER_IRQ_LINE);
    if (sgi_req) set_v = set_v | (16'h1 << sgi_code);
    if (wr && a == 8'h08) set_v = set_v | host_bus.wdata[15:0];
    clr_v = (wr && a == 8'h04) ? host_bus.wdata[15:0] : 16'h0;
    if (acked) clr_v = clr_v | (16'h1 << m_code);
    n_pend  = (m_pend & ~clr_v) | set_v;
    n_mask  = (wr && a == 8'h00) ? host_bus.wdata[15:0] : m_mask;
    n_resp  = rd;
    n_rdata = rd ? model_read(a) : m_rdata;
    n_stats = (wr && a == 8'h10) ? 32'h0 : (acked ? m_stats + 32'd1 : m_stats);
    n_req   = m_req;
    n_code  = m_code;
    first   = first_one(m_pend & m_mask);
    if (m_req) begin
      if (irq_ack) n_req = 1'b0;
    end else if (first >= 0) begin
      n_req  = 1'b1;
      n_code = 4'(first);
    end
    if (!rst_n) begin
      n_pend = 16'h0; n_mask = MASK_DEFAULT; n_req = 1'b0; n_code = 4'h0;
      n_resp = 1'b0; n_rdata = 32'h0; n_stats = 32'h0;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_mask = n_mask; m_req = n_req; m_code = n_code;
    m_resp = n_resp; m_rdata = n_rdata; m_stats = n_stats;
  endtask

  // ---------------- drive helpers ----------------
  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    host_bus.req = 1'b1; host_bus.we = 1'b1;
    host_bus.addr = {24'h0, a}; host_bus.wdata = d;
    step();
    host_bus.req = 1'b0; host_bus.we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d, output logic r);
    host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = {24'h0, a};
    step();
    host_bus.req = 1'b0;
    d = host_bus.rdata;
    r = host_bus.resp;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic r;
    rst_n = 1'b0;
    step(); step();
    checks++; if (irq_req !== 1'b0 || irq_code !== 4'h0) begin errors++;
      $display("FAIL reset_irq: got req=%0b code=%0d want req=0 code=0", irq_req, irq_code); end
    checks++; if (host_bus.resp !== 1'b0 || host_bus.rdata !== 32'h0) begin errors++;
      $display("FAIL reset_host: got resp=%0b rdata=%h want 0/0", host_bus.resp, host_bus.rdata); end
    rst_n = 1'b1;
    step();
    host_read(8'h00, d, r);
    checks++; if (r !== 1'b1 || d !== {16'h0, MASK_DEFAULT}) begin errors++;
      $display("FAIL reset_mask: got resp=%0b data=%h want 1/%h", r, d, MASK_DEFAULT); end
    host_read(8'h04, d, r);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL reset_pending: got %h want 0", d); end
    step();
    checks++; if (host_bus.resp !== 1'b0 || host_bus.rdata !== 32'h0) begin errors++;
      $display("FAIL resp_one_cycle: got resp=%0b rdata=%h want 0 and held 0", host_bus.resp, host_bus.rdata); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic r;
    host_write(8'h00, 32'h0002);
    irq_timer = 1'b1;
    step();
    irq_timer = 1'b0;
    checks++; if (irq_req !== 1'b0) begin errors++;
      $display("FAIL timer_n1: got req=%0b want 0", irq_req); end
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd1) begin errors++;
      $display("FAIL timer_n2: got req=%0b code=%0d want 1/1", irq_req, irq_code); end
    host_read(8'h0C, d, r);
    checks++; if (d !== 32'h8000_0001) begin errors++;
      $display("FAIL timer_status: got %h want 80000001", d); end
    do_ack();
    checks++; if (irq_req !== 1'b0) begin errors++;
      $display("FAIL timer_ack: got req=%0b want 0", irq_req); end
    host_read(8'h04, d, r);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL timer_pending: got %h want 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic r;
    host_write(8'h00, 32'hFFFF);
    host_write(8'h08, 32'h0030);
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd4) begin errors++;
      $display("FAIL prio_first: got req=%0b code=%0d want 1/4", irq_req, irq_code); end
    do_ack();
    checks++; if (irq_req !== 1'b0) begin errors++;
      $display("FAIL prio_gap: got req=%0b want 0", irq_req); end
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd5) begin errors++;
      $display("FAIL prio_second: got req=%0b code=%0d want 1/5", irq_req, irq_code); end
    sgi_req = 1'b1; sgi_code = 4'd2;
    step();
    sgi_req = 1'b0; sgi_code = $urandom_range(0, 15);
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd5) begin errors++;
      $display("FAIL prio_no_preempt: got req=%0b code=%0d want 1/5", irq_req, irq_code); end
    do_ack();
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd2) begin errors++;
      $display("FAIL prio_sgi: got req=%0b code=%0d want 1/2", irq_req, irq_code); end
    do_ack();
    step();
    host_read(8'h04, d, r);
    checks++; if (irq_req !== 1'b0 || d !== 32'h0) begin errors++;
      $display("FAIL prio_drain: got req=%0b pending=%h want 0/0", irq_req, d); end
  endtask

  task automatic test_masking();
    logic [31:0] d;
    logic r;
    host_write(8'h00, 32'h0);
    ext_irq = 16'h0100;
    step();
    ext_irq = 16'h0;
    step(); step();
    host_read(8'h04, d, r);
    checks++; if (irq_req !== 1'b0 || d !== 32'h0100) begin errors++;
      $display("FAIL mask_hold: got req=%0b pending=%h want 0/00000100", irq_req, d); end
    host_write(8'h00, 32'h0100);
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd8) begin errors++;
      $display("FAIL mask_enable: got req=%0b code=%0d want 1/8", irq_req, irq_code); end
    host_write(8'h00, 32'h0);
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd8) begin errors++;
      $display("FAIL mask_no_withdraw: got req=%0b code=%0d want 1/8", irq_req, irq_code); end
    do_ack();
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic r;
    host_write(8'h00, 32'h0);
    host_bus.req = 1'b1; host_bus.we = 1'b1; host_bus.addr = 32'h4; host_bus.wdata = 32'h0008;
    ext_irq = 16'h0008;
    step();
    host_bus.req = 1'b0; host_bus.we = 1'b0; ext_irq = 16'h0;
    host_read(8'h04, d, r);
    checks++; if (d !== 32'h0008) begin errors++;
      $display("FAIL w1c_vs_set: got pending=%h want 00000008", d); end
    host_write(8'h04, 32'hFFFF);
    host_write(8'h00, 32'h0040);
    ext_irq = 16'h0040;
    step();
    ext_irq = 16'h0;
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd6) begin errors++;
      $display("FAIL rearr_first: got req=%0b code=%0d want 1/6", irq_req, irq_code); end
    ext_irq = 16'h0040;
    do_ack();
    ext_irq = 16'h0;
    checks++; if (irq_req !== 1'b0) begin errors++;
      $display("FAIL rearr_gap: got req=%0b want 0", irq_req); end
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd6) begin errors++;
      $display("FAIL rearr_again: got req=%0b code=%0d want 1/6", irq_req, irq_code); end
    host_write(8'h04, 32'h0040);
    step();
    checks++; if (irq_req !== 1'b1 || irq_code !== 4'd6) begin errors++;
      $display("FAIL w1c_inflight: got req=%0b code=%0d want 1/6", irq_req, irq_code); end
    do_ack();
    step();
    checks++; if (irq_req !== 1'b0) begin errors++;
      $display("FAIL w1c_inflight_done: got req=%0b want 0", irq_req); end
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] d;
    logic r;
    host_write(8'h00, 32'hFFFF);
    host_write(8'h08, 32'h0201);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (irq_req !== 1'b0) begin errors++;
      $display("FAIL rst_mid_req: got req=%0b want 0", irq_req); end
    host_read(8'h04, d, r);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL rst_mid_pending: got %h want 0", d); end
  endtask

  task automatic test_stats();
    logic [31:0] d;
    logic r;
    host_write(8'h00, 32'hFFFF);
    host_write(8'h10, 32'h0);
    for (int k = 0; k < 3; k++) begin
      host_write(8'h08, 32'h0008);
      step();
      do_ack();
      step();
    end
    host_read(8'h10, d, r);
    checks++; if (d !== (STATS_ON ? 32'd3 : 32'd0)) begin errors++;
      $display("FAIL stats_count: got %h want %h", d, STATS_ON ? 32'd3 : 32'd0); end
    host_write(8'h10, 32'h1234);
    host_read(8'h10, d, r);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL stats_clear: got %h want 0", d); end
  endtask

  task automatic test_random();
    logic [7:0] addr_tbl [7];
    int bad;
    addr_tbl = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40};
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      ext_irq   = ($urandom_range(0, 5) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      irq_timer = ($urandom_range(0, 9) == 0);
      sgi_req   = ($urandom_range(0, 9) == 0);
      sgi_code  = 4'($urandom_range(0, 15));
      irq_ack   = ($urandom_range(0, 2) == 0);
      host_bus.req   = ($urandom_range(0, 3) == 0);
      host_bus.we    = $urandom_range(0, 1);
      host_bus.addr  = {24'h0, addr_tbl[$urandom_range(0, 6)]};
      host_bus.wdata = $urandom;
      #1;
      checks++; if (host_bus.ack !== host_bus.req) begin errors++; bad++;
        if (bad < 10) $display("FAIL rnd_ack c=%0d: got %0b want %0b", c, host_bus.ack, host_bus.req); end
      step();
      checks++; if (irq_req !== m_req || (m_req && irq_code !== m_code)) begin errors++; bad++;
        if (bad < 10) $display("FAIL rnd_irq c=%0d: got req=%0b code=%0d want req=%0b code=%0d",
                               c, irq_req, irq_code, m_req, m_code); end
      checks++; if (host_bus.resp !== m_resp || host_bus.rdata !== m_rdata) begin errors++; bad++;
        if (bad < 10) $display("FAIL rnd_host c=%0d: got resp=%0b rdata=%h want resp=%0b rdata=%h",
                               c, host_bus.resp, host_bus.rdata, m_resp, m_rdata); end
    end
    ext_irq = 16'h0; irq_timer = 1'b0; sgi_req = 1'b0; irq_ack = 1'b0;
    host_bus.req = 1'b0; host_bus.we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_timer = 1'b0; sgi_req = 1'b0; sgi_code = 4'h0;
    ext_irq = 16'h0; irq_ack = 1'b0;
    host_bus.req = 1'b0; host_bus.we = 1'b0; host_bus.addr = 32'h0; host_bus.wdata = 32'h0;
    m_pend = 16'h0; m_mask = MASK_DEFAULT; m_req = 1'b0; m_code = 4'h0;
    m_resp = 1'b0; m_rdata = 32'h0; m_stats = 32'h0;
    test_reset();
    test_timer();
    test_priority();
    test_masking();
    test_collision();
    test_reset_mid_req();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
